alu_reservation_station: RTL

Tomasulo-style reservation station that feeds the LC-3b ALU. Holds up to DEPTH dispatched ALU operations and captures missing operands by snooping the common data bus (CDB). It issues the oldest operation whose operands are both available as an (aluop, a, b, tag) bundle to the ALU stage over a valid/ready handshake. It sits between the dispatch/rename stage and the ALU functional unit.

---
 rtl/alu_reservation_station.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/alu_reservation_station.sv
// ---------------------------------------------------------------------------
// alu_reservation_station
//
// Tomasulo-style reservation station in front of the LC-3b ALU. Holds up to
// DEPTH dispatched operations in a compacting, age-ordered queue (slot 0 is
// the oldest), wakes up missing operands by snooping the CDB, and offers the
// oldest fully-ready entry to the ALU over a valid/ready handshake.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   flush                     squash every entry at the next edge
//   dispatch_*                incoming operation (valid/ready handshake)
//   cdb_valid/tag/value       result broadcast from the common data bus
//   issue_*                   selected (aluop, a, b, tag) bundle to the ALU
// ---------------------------------------------------------------------------
package lc3b_types;
    typedef enum logic [2:0] {
        alu_add,
        alu_and,
        alu_not,
        alu_pass,
        alu_sll,
        alu_srl,
        alu_sra
    } lc3b_aluop;
endpackage

module alu_reservation_station
    import lc3b_types::*;
#(
    parameter int DEPTH     = 4,
    parameter int TAG_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 dispatch_valid,
    output logic                 dispatch_ready,
    input  lc3b_aluop            dispatch_aluop,
    input  logic [TAG_WIDTH-1:0] dispatch_tag,
    input  logic                 dispatch_a_valid,
    input  logic [15:0]          dispatch_a_value,
    input  logic [TAG_WIDTH-1:0] dispatch_a_tag,
    input  logic                 dispatch_b_valid,
    input  logic [15:0]          dispatch_b_value,
    input  logic [TAG_WIDTH-1:0] dispatch_b_tag,
    input  logic                 cdb_valid,
    input  logic [TAG_WIDTH-1:0] cdb_tag,
    input  logic [15:0]          cdb_value,
    output logic                 issue_valid,
    input  logic                 issue_ready,
    output lc3b_aluop            issue_aluop,
    output logic [15:0]          issue_a,
    output logic [15:0]          issue_b,
    output logic [TAG_WIDTH-1:0] issue_tag
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    typedef struct packed {
        lc3b_aluop            aluop;
        logic [TAG_WIDTH-1:0] tag;
        logic                 a_valid;
        logic [15:0]          a_value;
        logic [TAG_WIDTH-1:0] a_tag;
        logic                 b_valid;
        logic [15:0]          b_value;
        logic [TAG_WIDTH-1:0] b_tag;
    } entry_t;

    entry_t          entry_q [DEPTH];
    entry_t          entry_d [DEPTH];
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic [CW-1:0]   post_count;
    logic [DEPTH-1:0] ready;
    logic [IW-1:0]   sel_idx;
    logic            any_ready;
    logic            fire;
    logic            accept;
    entry_t          disp_entry;
    entry_t          sel_entry;

    // Capture a CDB result into any still-waiting operand with a matching tag.
    // Operands that are already valid are left untouched.
    function automatic entry_t snoop(input entry_t e, input logic cv,
                                     input logic [TAG_WIDTH-1:0] ct,
                                     input logic [15:0] val);
        entry_t r;
        r = e;
        if (cv && !e.a_valid && (e.a_tag == ct)) begin
            r.a_valid = 1'b1;
            r.a_value = val;
        end
        if (cv && !e.b_valid && (e.b_tag == ct)) begin
            r.b_valid = 1'b1;
            r.b_value = val;
        end
        return r;
    endfunction

    // Ready vector, gated by occupancy so stale slots can never be selected.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_ready
        assign ready[gi] = (gi < int'(count_q)) && entry_q[gi].a_valid && entry_q[gi].b_valid;
    end

    // Oldest-ready select: scan from the top so the lowest index wins.
    always_comb begin
        sel_idx   = '0;
        any_ready = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready[i]) begin
                sel_idx   = IW'(i);
                any_ready = 1'b1;
            end
        end
    end

    assign sel_entry      = entry_q[sel_idx];
    assign issue_valid    = any_ready;
    assign issue_aluop    = any_ready ? sel_entry.aluop   : alu_add;
    assign issue_a        = any_ready ? sel_entry.a_value : 16'h0000;
    assign issue_b        = any_ready ? sel_entry.b_value : 16'h0000;
    assign issue_tag      = any_ready ? sel_entry.tag     : '0;
    assign dispatch_ready = (count_q < CW'(DEPTH));

    // Flush suppresses both handshakes even if they occurred this cycle.
    assign fire       = any_ready && issue_ready && !flush;
    assign accept     = dispatch_valid && dispatch_ready && !flush;
    assign post_count = count_q - CW'(fire);
    assign count_d    = flush ? '0 : (post_count + CW'(accept));

    always_comb begin
        disp_entry.aluop   = dispatch_aluop;
        disp_entry.tag     = dispatch_tag;
        disp_entry.a_valid = dispatch_a_valid;
        disp_entry.a_value = dispatch_a_value;
        disp_entry.a_tag   = dispatch_a_tag;
        disp_entry.b_valid = dispatch_b_valid;
        disp_entry.b_value = dispatch_b_value;
        disp_entry.b_tag   = dispatch_b_tag;
    end

    // Next slot contents: a new dispatch lands at the post-issue count; slots
    // at or above the issued one pull from their upper neighbour; everything
    // occupied is snooped on the way through.
    always_comb begin
        int src;
        src = 0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_d[i] = '0;
            src        = (i + 1 < DEPTH) ? i + 1 : i;
            if (flush) begin
                entry_d[i] = '0;
            end else if (accept && (CW'(i) == post_count)) begin
                entry_d[i] = snoop(disp_entry, cdb_valid, cdb_tag, cdb_value);
            end else if (fire && (i >= int'(sel_idx))) begin
                if ((i + 1 < DEPTH) && (i + 1 < int'(count_q))) begin
                    entry_d[i] = snoop(entry_q[src], cdb_valid, cdb_tag, cdb_value);
                end
            end else if (i < int'(count_q)) begin
                entry_d[i] = snoop(entry_q[i], cdb_valid, cdb_tag, cdb_value);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
        end
    end

endmodule
